// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: machine-mode interrupt controller beside the CSR unit.
// Owns mstatus.MIE/MPIE, mie and mip, prioritises MEI > MSI > MTI and
// requests a trap at instruction boundaries with a req/ack handshake.
// Build macro CSR_IRQ_TIMER_EN adds an internal mtime/mtimecmp timer that
// replaces mtip_i as the timer interrupt source.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; an interrupt may be accepted on retire_i
// REQ   | trap requested, cause held stable until irq_ack_i
module csr_irq_ctrl #(
    parameter int Xlen       = 32,
    parameter int SyncStages = 2,
    parameter int TimerWidth = Xlen
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            msip_i,
    input  logic            mtip_i,
    input  logic            meip_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [Xlen-1:0] csr_wdata_i,
    output logic [Xlen-1:0] csr_rdata_o,
    input  logic            retire_i,
    input  logic            mret_i,
    output logic            irq_req_o,
    output logic [Xlen-1:0] irq_cause_o,
    input  logic            irq_ack_i
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MTIME    = 12'h7C0;
    localparam logic [11:0] ADDR_MTIMECMP = 12'h7C1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SyncStages-1:0] meip_sync_q;
    logic                  meip_s;
    logic                  mstatus_mie_q;
    logic                  mstatus_mpie_q;
    logic                  mie_msie_q;
    logic                  mie_mtie_q;
    logic                  mie_meie_q;
    logic                  mtip;
    logic                  pend_msi;
    logic                  pend_mti;
    logic                  pend_mei;
    logic                  fire;
    logic                  ack_take;
    logic                  mret_take;
    logic                  wr_mstatus;
    logic                  wr_mie;
    logic [3:0]            code;
    logic [Xlen-1:0]       cause_q;
    logic [Xlen-1:0]       cause_d;
    logic                  unused_inputs;

    // Only a few write-data bits land in registers; the rest are don't-care.
    assign unused_inputs = ^{csr_wdata_i, mtip_i};

    assign wr_mstatus = csr_we_i && (csr_addr_i == ADDR_MSTATUS);
    assign wr_mie     = csr_we_i && (csr_addr_i == ADDR_MIE);

    // meip_i is asynchronous: shift it through a synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meip_sync_q <= '0;
        end else begin
            meip_sync_q <= {meip_sync_q[SyncStages-2:0], meip_i};
        end
    end

    assign meip_s = meip_sync_q[SyncStages-1];

`ifdef CSR_IRQ_TIMER_EN
    logic [TimerWidth-1:0] mtime_q;
    logic [TimerWidth-1:0] mtimecmp_q;
    logic                  mtip_q;

    // Free-running mtime, writable mtimecmp and a registered compare.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q <= mtime_q + TimerWidth'(1);
            mtip_q  <= (mtime_q >= mtimecmp_q);
            if (csr_we_i && (csr_addr_i == ADDR_MTIMECMP)) begin
                mtimecmp_q <= csr_wdata_i[TimerWidth-1:0];
            end
        end
    end

    assign mtip = mtip_q;
`else
    logic [TimerWidth-1:0] unused_timer_width;

    // No timer hardware: the width parameter is simply carried along.
    assign unused_timer_width = '0;
    assign mtip               = mtip_i;
`endif

    // mie: only MSIE, MTIE and MEIE exist.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_msie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
        end else if (wr_mie) begin
            mie_msie_q <= csr_wdata_i[3];
            mie_mtie_q <= csr_wdata_i[7];
            mie_meie_q <= csr_wdata_i[11];
        end
    end

    // mstatus.MIE/MPIE: trap entry beats mret, which beats a CSR write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (ack_take) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_take) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie_q  <= csr_wdata_i[3];
            mstatus_mpie_q <= csr_wdata_i[7];
        end
    end

    assign pend_msi = msip_i & mie_msie_q;
    assign pend_mti = mtip   & mie_mtie_q;
    assign pend_mei = meip_s & mie_meie_q;
    assign fire     = mstatus_mie_q & (pend_msi | pend_mti | pend_mei) & retire_i;

    // Next-state, cause selection and handshake qualifiers.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        ack_take  = 1'b0;
        mret_take = 1'b0;
        code      = 4'd7;
        if (pend_mei) begin
            code = 4'd11;
        end else if (pend_msi) begin
            code = 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                mret_take = mret_i;
                if (fire) begin
                    state_d = ST_REQ;
                    cause_d = {1'b1, {(Xlen-5){1'b0}}, code};
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d  = ST_IDLE;
                    ack_take = 1'b1;
                end
            end
        endcase
    end

    // State register and latched cause.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign irq_req_o   = (state_q == ST_REQ);
    assign irq_cause_o = cause_q;

    // Combinational CSR read mux; unowned addresses read zero.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_MSTATUS: begin
                csr_rdata_o[3]     = mstatus_mie_q;
                csr_rdata_o[7]     = mstatus_mpie_q;
                csr_rdata_o[12:11] = 2'b11;
            end
            ADDR_MIE: begin
                csr_rdata_o[3]  = mie_msie_q;
                csr_rdata_o[7]  = mie_mtie_q;
                csr_rdata_o[11] = mie_meie_q;
            end
            ADDR_MIP: begin
                csr_rdata_o[3]  = msip_i;
                csr_rdata_o[7]  = mtip;
                csr_rdata_o[11] = meip_s;
            end
`ifdef CSR_IRQ_TIMER_EN
            ADDR_MTIME:    csr_rdata_o = Xlen'(mtime_q);
            ADDR_MTIMECMP: csr_rdata_o = Xlen'(mtimecmp_q);
`endif
            default: csr_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Testbench for csr_irq_ctrl: directed scenarios followed by a random phase,
// all checked each cycle against a behavioural model of the CSR/trap rules.
module tb_csr_irq_ctrl;

    localparam int Xlen       = 32;
    localparam int SyncStages = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            msip_i;
    logic            mtip_i;
    logic            meip_i;
    logic            csr_we_i;
    logic [11:0]     csr_addr_i;
    logic [Xlen-1:0] csr_wdata_i;
    logic [Xlen-1:0] csr_rdata_o;
    logic            retire_i;
    logic            mret_i;
    logic            irq_req_o;
    logic [Xlen-1:0] irq_cause_o;
    logic            irq_ack_i;

    csr_irq_ctrl #(.Xlen(Xlen), .SyncStages(SyncStages)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .msip_i      (msip_i),
        .mtip_i      (mtip_i),
        .meip_i      (meip_i),
        .csr_we_i    (csr_we_i),
        .csr_addr_i  (csr_addr_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o),
        .retire_i    (retire_i),
        .mret_i      (mret_i),
        .irq_req_o   (irq_req_o),
        .irq_cause_o (irq_cause_o),
        .irq_ack_i   (irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              m_req;
    logic [Xlen-1:0] m_cause;
    bit              m_mie;
    bit              m_mpie;
    logic [11:0]     m_ie;
    bit              meip_q[$];
    logic [Xlen-1:0] m_time;
    logic [Xlen-1:0] m_cmp;
    bit              m_mtip;

    task automatic chk(input string tag, input logic [Xlen-1:0] obs, input logic [Xlen-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req   = 1'b0;
        m_cause = '0;
        m_mie   = 1'b0;
        m_mpie  = 1'b0;
        m_ie    = '0;
        m_time  = '0;
        m_cmp   = '1;
        m_mtip  = 1'b0;
        meip_q.delete();
        repeat (SyncStages) meip_q.push_back(1'b0);
    endtask

    function automatic bit mtip_now();
`ifdef CSR_IRQ_TIMER_EN
        return m_mtip;
`else
        return mtip_i;
`endif
    endfunction

    // meip as seen SyncStages edges ago
    function automatic logic [11:0] mip_now();
        logic [11:0] v;
        v     = '0;
        v[3]  = msip_i;
        v[7]  = mtip_now();
        v[11] = meip_q[0];
        return v;
    endfunction

    function automatic logic [Xlen-1:0] cause_of(input logic [11:0] p);
        int code;
        code = p[11] ? 11 : (p[3] ? 3 : 7);
        return (Xlen'(1) << (Xlen - 1)) | Xlen'(code);
    endfunction

    function automatic logic [Xlen-1:0] exp_rdata(input logic [11:0] a);
        logic [Xlen-1:0] v;
        v = '0;
        case (a)
            12'h300: v = (Xlen'(m_mie) << 3) | (Xlen'(m_mpie) << 7) | (Xlen'(3) << 11);
            12'h304: v = Xlen'(m_ie);
            12'h344: v = Xlen'(mip_now());
`ifdef CSR_IRQ_TIMER_EN
            12'h7C0: v = m_time;
            12'h7C1: v = m_cmp;
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    task automatic model_edge();
        logic [11:0] pend;
        bit          ack_t;
        bit          mret_t;
        bit          nt;
        pend   = mip_now() & m_ie;
        ack_t  = m_req && irq_ack_i;
        mret_t = !m_req && mret_i;
        if (!m_req) begin
            if (m_mie && (pend != 0) && retire_i) begin
                m_req   = 1'b1;
                m_cause = cause_of(pend);
            end
        end else if (irq_ack_i) begin
            m_req = 1'b0;
        end
        if (ack_t) begin
            m_mpie = m_mie;
            m_mie  = 1'b0;
        end else if (mret_t) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end else if (csr_we_i && csr_addr_i == 12'h300) begin
            m_mie  = csr_wdata_i[3];
            m_mpie = csr_wdata_i[7];
        end
        if (csr_we_i && csr_addr_i == 12'h304) m_ie = csr_wdata_i[11:0] & 12'h888;
        nt = (m_time >= m_cmp);
        if (csr_we_i && csr_addr_i == 12'h7C1) m_cmp = csr_wdata_i;
        m_time = m_time + 1;
        m_mtip = nt;
        meip_q.push_back(meip_i);
        void'(meip_q.pop_front());
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic cycle();
        #1;
        chk("req", Xlen'(irq_req_o), Xlen'(m_req));
        chk("cause", irq_cause_o, m_cause);
        chk("rdata", csr_rdata_o, exp_rdata(csr_addr_i));
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        msip_i      = 1'b0;
        mtip_i      = 1'b0;
        meip_i      = 1'b0;
        csr_we_i    = 1'b0;
        csr_addr_i  = 12'h300;
        csr_wdata_i = '0;
        retire_i    = 1'b0;
        mret_i      = 1'b0;
        irq_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [Xlen-1:0] d);
        csr_we_i    = 1'b1;
        csr_addr_i  = a;
        csr_wdata_i = d;
        cycle();
        csr_we_i    = 1'b0;
        csr_addr_i  = 12'h300;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [Xlen-1:0] exp);
        csr_addr_i = a;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask

    initial begin
        bit got;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_req", Xlen'(irq_req_o), '0);
        chk("rst_cause", irq_cause_o, '0);
        chk_rd("rst_mstatus", 12'h300, 32'h0000_1800);
        chk_rd("rst_mie", 12'h304, 32'h0);
        cycle();

        // Priority: all three pending, MEI wins
        wr(12'h304, 32'hFFFF_FFFF);
        chk_rd("mie_mask", 12'h304, 32'h0000_0888);
        wr(12'h300, 32'h8);
        msip_i = 1'b1; meip_i = 1'b1; mtip_i = 1'b1;
        repeat (3) cycle();
        retire_i = 1'b1;
        cycle();
        retire_i = 1'b0;
        chk("prio_req", Xlen'(irq_req_o), 32'h1);
        chk("prio_cause", irq_cause_o, 32'h8000_000B);

        // Hold: sources drop, request and cause stay; retire/mret ignored in REQ
        msip_i = 1'b0; meip_i = 1'b0; mtip_i = 1'b0;
        retire_i = 1'b1; mret_i = 1'b1;
        repeat (5) cycle();
        retire_i = 1'b0; mret_i = 1'b0;
        chk("hold_req", Xlen'(irq_req_o), 32'h1);
        chk("hold_cause", irq_cause_o, 32'h8000_000B);
        irq_ack_i = 1'b1;
        cycle();
        irq_ack_i = 1'b0;
        chk("ack_req", Xlen'(irq_req_o), 32'h0);
        chk_rd("ack_mstatus", 12'h300, 32'h0000_1880);

        // mret in IDLE after the trap
        mret_i = 1'b1;
        cycle();
        mret_i = 1'b0;
        chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Software interrupt, then ack colliding with mstatus write
        msip_i = 1'b1;
        retire_i = 1'b1;
        cycle();
        retire_i = 1'b0;
        chk("msi_cause", irq_cause_o, 32'h8000_0003);
        irq_ack_i = 1'b1;
        wr(12'h300, 32'h8);
        irq_ack_i = 1'b0;
        chk_rd("collide_mstatus", 12'h300, 32'h0000_1880);

        // Masking: pending but MIE=0; enabling write does not fire same cycle
        retire_i = 1'b1;
        repeat (3) cycle();
        chk("mask_req", Xlen'(irq_req_o), 32'h0);
        wr(12'h300, 32'h8);
        chk("mask_same_cycle", Xlen'(irq_req_o), 32'h0);
        cycle();
        retire_i = 1'b0;
        chk("unmask_req", Xlen'(irq_req_o), 32'h1);
        chk("unmask_cause", irq_cause_o, 32'h8000_0003);
        irq_ack_i = 1'b1;
        cycle();
        irq_ack_i = 1'b0;

        // Asynchronous reset in the middle of REQ
        wr(12'h300, 32'h8);
        retire_i = 1'b1;
        cycle();
        retire_i = 1'b0;
        chk("pre_rst_req", Xlen'(irq_req_o), 32'h1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_req", Xlen'(irq_req_o), 32'h0);
        chk("arst_cause", irq_cause_o, 32'h0);
        chk_rd("arst_mstatus", 12'h300, 32'h0000_1800);
        chk_rd("arst_mie", 12'h304, 32'h0);
        idle_inputs();
        do_reset();

        // Timer source
`ifdef CSR_IRQ_TIMER_EN
        wr(12'h7C1, m_time + 32'd10);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        retire_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 14 && !got; k++) begin
            cycle();
            got = irq_req_o;
        end
        retire_i = 1'b0;
        chk("timer_req", Xlen'(got), 32'h1);
        chk("timer_cause", irq_cause_o, 32'h8000_0007);
`else
        mtip_i = 1'b1;
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        retire_i = 1'b1;
        cycle();
        retire_i = 1'b0;
        got = irq_req_o;
        chk("timer_req", Xlen'(got), 32'h1);
        chk("timer_cause", irq_cause_o, 32'h8000_0007);
`endif
        irq_ack_i = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            msip_i      = ($urandom_range(0, 3) == 0);
            mtip_i      = ($urandom_range(0, 3) == 0);
            meip_i      = ($urandom_range(0, 4) == 0);
            retire_i    = $urandom_range(0, 1);
            irq_ack_i   = ($urandom_range(0, 2) == 0);
            mret_i      = ($urandom_range(0, 5) == 0);
            csr_we_i    = ($urandom_range(0, 3) == 0);
            csr_wdata_i = $urandom;
            case ($urandom_range(0, 5))
                0: csr_addr_i = 12'h300;
                1: csr_addr_i = 12'h304;
                2: csr_addr_i = 12'h344;
                3: csr_addr_i = 12'h7C0;
                4: csr_addr_i = 12'h7C1;
                default: csr_addr_i = 12'($urandom);
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
